// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register: shared types and the decode/execute bus interface.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN (adds bubble_cnt_o to the bus).
package id_ex_pkg;
  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
endpackage

interface id_ex_pipe_reg_if #(parameter int DATA_W = 32);
  import id_ex_pkg::*;

  logic                   if_id_valid_i;
  logic [6:0]             if_id_opcode_i;
  logic [4:0]             if_id_rs1_i;
  logic [4:0]             if_id_rs2_i;
  logic [4:0]             if_id_rd_i;
  write_back_mux_selector if_id_wb_mux_i;
  logic [DATA_W-1:0]      if_id_rs1_data_i;
  logic [DATA_W-1:0]      if_id_rs2_data_i;
  logic [DATA_W-1:0]      if_id_imm_i;
  logic                   branch_flush_i;

  logic                   id_ex_valid_o;
  logic [6:0]             id_ex_opcode_o;
  logic [4:0]             id_ex_rs1_o;
  logic [4:0]             id_ex_rs2_o;
  logic [4:0]             id_ex_rd_o;
  write_back_mux_selector id_ex_wb_mux_o;
  logic [DATA_W-1:0]      id_ex_rs1_data_o;
  logic [DATA_W-1:0]      id_ex_rs2_data_o;
  logic [DATA_W-1:0]      id_ex_imm_o;
  logic                   stall_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0]            bubble_cnt_o;
`endif

  // Decode stage / testbench side: drives IF/ID fields, observes ID/EX fields.
  modport master (
    output if_id_valid_i, if_id_opcode_i, if_id_rs1_i, if_id_rs2_i, if_id_rd_i,
           if_id_wb_mux_i, if_id_rs1_data_i, if_id_rs2_data_i, if_id_imm_i,
           branch_flush_i,
    input  id_ex_valid_o, id_ex_opcode_o, id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o,
           id_ex_wb_mux_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
`ifdef ID_EX_BUBBLE_CNT_EN
           bubble_cnt_o,
`endif
           stall_o
  );

  // Pipeline register side.
  modport slave (
    input  if_id_valid_i, if_id_opcode_i, if_id_rs1_i, if_id_rs2_i, if_id_rd_i,
           if_id_wb_mux_i, if_id_rs1_data_i, if_id_rs2_data_i, if_id_imm_i,
           branch_flush_i,
    output id_ex_valid_o, id_ex_opcode_o, id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o,
           id_ex_wb_mux_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
`ifdef ID_EX_BUBBLE_CNT_EN
           bubble_cnt_o,
`endif
           stall_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the decode-stage instruction
// raises stall_o for one cycle and inserts a bubble; a branch flush squashes
// the decode-stage instruction. Macro ID_EX_BUBBLE_CNT_EN adds a saturating
// count of load-use bubbles on bubble_cnt_o.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  id_ex_pipe_reg_if.slave    bus
);

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    write_back_mux_selector wb_mux;
    logic [DATA_W-1:0]      rs1_data;
    logic [DATA_W-1:0]      rs2_data;
    logic [DATA_W-1:0]      imm;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{
    valid:    1'b0,
    opcode:   7'd0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    wb_mux:   NO_WRITEBACK,
    rs1_data: {DATA_W{1'b0}},
    rs2_data: {DATA_W{1'b0}},
    imm:      {DATA_W{1'b0}}
  };

  id_ex_t r_stage;
  id_ex_t w_next;
  logic   w_rs1_used;
  logic   w_rs2_used;
  logic   w_stall;

  // Decode which source registers the decode-stage opcode actually reads.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (bus.if_id_opcode_i)
      OPCODE_OP:     begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OPCODE_STORE:  begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OPCODE_BRANCH: begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OPCODE_OPIMM:  begin w_rs1_used = 1'b1; w_rs2_used = 1'b0; end
      OPCODE_LOAD:   begin w_rs1_used = 1'b1; w_rs2_used = 1'b0; end
      OPCODE_JALR:   begin w_rs1_used = 1'b1; w_rs2_used = 1'b0; end
      default:       begin w_rs1_used = 1'b0; w_rs2_used = 1'b0; end
    endcase
  end

  // Load-use hazard: suppressed during reset and flush so a squashed
  // instruction never holds the front end.
  assign w_stall = !reset && !bus.branch_flush_i &&
                   r_stage.valid && (r_stage.opcode == OPCODE_LOAD) &&
                   (r_stage.rd != 5'd0) && bus.if_id_valid_i &&
                   ((w_rs1_used && (bus.if_id_rs1_i == r_stage.rd)) ||
                    (w_rs2_used && (bus.if_id_rs2_i == r_stage.rd)));

  // Next ID/EX contents: bubble on flush or stall, otherwise capture decode.
  always_comb begin
    w_next = BUBBLE;
    if (bus.branch_flush_i || w_stall) begin
      w_next = BUBBLE;
    end else begin
      w_next.valid    = bus.if_id_valid_i;
      w_next.opcode   = bus.if_id_opcode_i;
      w_next.rs1      = bus.if_id_rs1_i;
      w_next.rs2      = bus.if_id_rs2_i;
      w_next.rs1_data = bus.if_id_rs1_data_i;
      w_next.rs2_data = bus.if_id_rs2_data_i;
      w_next.imm      = bus.if_id_imm_i;
      if (bus.if_id_valid_i) begin
        w_next.rd     = bus.if_id_rd_i;
        w_next.wb_mux = bus.if_id_wb_mux_i;
      end else begin
        // Invalid slots must never write back or look like a load producer.
        w_next.rd     = 5'd0;
        w_next.wb_mux = NO_WRITEBACK;
      end
    end
  end

  // ID/EX register; reset overrides everything including a pending stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= BUBBLE;
    end else begin
      r_stage <= w_next;
    end
  end

  assign bus.id_ex_valid_o    = r_stage.valid;
  assign bus.id_ex_opcode_o   = r_stage.opcode;
  assign bus.id_ex_rs1_o      = r_stage.rs1;
  assign bus.id_ex_rs2_o      = r_stage.rs2;
  assign bus.id_ex_rd_o       = r_stage.rd;
  assign bus.id_ex_wb_mux_o   = r_stage.wb_mux;
  assign bus.id_ex_rs1_data_o = r_stage.rs1_data;
  assign bus.id_ex_rs2_data_o = r_stage.rs2_data;
  assign bus.id_ex_imm_o      = r_stage.imm;
  assign bus.stall_o          = w_stall;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Count load-use bubbles only (w_stall already excludes flush), saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed rows push the expected
// per-cycle outputs; a monitor on the falling edge pops and compares.
module tb_id_ex_pipe_reg;
  import id_ex_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  id_ex_pipe_reg_if #(.DATA_W(32)) bus ();

  id_ex_pipe_reg #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic                   v;
    logic [6:0]             op;
    logic [4:0]             s1;
    logic [4:0]             s2;
    logic [4:0]             d;
    write_back_mux_selector wb;
    logic [31:0]            a;
    logic [31:0]            b;
    logic [31:0]            im;
    logic                   st;
    logic [31:0]            cnt;
  } exp_t;

  exp_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of decode-stage inputs shortly after the rising edge.
  task automatic drv(input logic rst, input logic fl, input logic v, input logic [6:0] op,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                     input write_back_mux_selector wb,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(posedge clk);
    #2;
    reset                = rst;
    bus.branch_flush_i   = fl;
    bus.if_id_valid_i    = v;
    bus.if_id_opcode_i   = op;
    bus.if_id_rs1_i      = s1;
    bus.if_id_rs2_i      = s2;
    bus.if_id_rd_i       = d;
    bus.if_id_wb_mux_i   = wb;
    bus.if_id_rs1_data_i = a;
    bus.if_id_rs2_data_i = b;
    bus.if_id_imm_i      = im;
  endtask

  // Expected outputs during the cycle just driven.
  task automatic ex(input logic v, input logic [6:0] op, input logic [4:0] s1,
                    input logic [4:0] s2, input logic [4:0] d, input write_back_mux_selector wb,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                    input logic st, input logic [31:0] cnt);
    exp_t e;
    e.v = v; e.op = op; e.s1 = s1; e.s2 = s2; e.d = d; e.wb = wb;
    e.a = a; e.b = b; e.im = im; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid",    {31'd0, bus.id_ex_valid_o},   {31'd0, e.v});
        chk("opcode",   {25'd0, bus.id_ex_opcode_o},  {25'd0, e.op});
        chk("rs1",      {27'd0, bus.id_ex_rs1_o},     {27'd0, e.s1});
        chk("rs2",      {27'd0, bus.id_ex_rs2_o},     {27'd0, e.s2});
        chk("rd",       {27'd0, bus.id_ex_rd_o},      {27'd0, e.d});
        chk("wb_mux",   {30'd0, bus.id_ex_wb_mux_o},  {30'd0, e.wb});
        chk("rs1_data", bus.id_ex_rs1_data_o,         e.a);
        chk("rs2_data", bus.id_ex_rs2_data_o,         e.b);
        chk("imm",      bus.id_ex_imm_o,              e.im);
        chk("stall",    {31'd0, bus.stall_o},         {31'd0, e.st});
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_cnt", bus.bubble_cnt_o,           e.cnt);
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus rows: drv = inputs this cycle, ex = outputs this cycle.
  initial begin
    reset = 1'b1;
    bus.branch_flush_i = 1'b0; bus.if_id_valid_i = 1'b0; bus.if_id_opcode_i = 7'd0;
    bus.if_id_rs1_i = 5'd0; bus.if_id_rs2_i = 5'd0; bus.if_id_rd_i = 5'd0;
    bus.if_id_wb_mux_i = NO_WRITEBACK; bus.if_id_rs1_data_i = 32'd0;
    bus.if_id_rs2_data_i = 32'd0; bus.if_id_imm_i = 32'd0;

    // Reset held with a live instruction on the inputs: outputs bubble.
    drv(1'b1, 1'b0, 1'b1, OPCODE_OP, 5'd9, 5'd9, 5'd9, WB_ALU, 32'd1, 32'd1, 32'd1);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    // ADD x3,x1,x2
    drv(1'b0, 1'b0, 1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, WB_ALU, 32'd5, 32'd7, 32'd0);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    // LW x5; ADD captured with one-cycle latency
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8);
    ex (1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, WB_ALU, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0);
    // ADD x6,x5,x1 behind LW x5: load-use stall
    drv(1'b0, 1'b0, 1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0);
    ex (1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8, 1'b1, 32'd0);
    // Same ADD held: bubble in ID/EX, stall released
    drv(1'b0, 1'b0, 1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd1);
    // LW x0; ADD now captured
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd3, 5'd0, 5'd0, WB_MEM, 32'd1, 32'd0, 32'd4);
    ex (1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0, 1'b0, 32'd1);
    // ADD x6,x0,x1 behind LW x0: no stall
    drv(1'b0, 1'b0, 1'b1, OPCODE_OP, 5'd0, 5'd1, 5'd6, WB_ALU, 32'd0, 32'd22, 32'd0);
    ex (1'b1, OPCODE_LOAD, 5'd3, 5'd0, 5'd0, WB_MEM, 32'd1, 32'd0, 32'd4, 1'b0, 32'd1);
    // LW x5
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8);
    ex (1'b1, OPCODE_OP, 5'd0, 5'd1, 5'd6, WB_ALU, 32'd0, 32'd22, 32'd0, 1'b0, 32'd1);
    // OPIMM rd=6 rs1=1, rs2 field=5 unused: no stall
    drv(1'b0, 1'b0, 1'b1, OPCODE_OPIMM, 5'd1, 5'd5, 5'd6, WB_ALU, 32'd3, 32'd9, 32'd12);
    ex (1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8, 1'b0, 32'd1);
    // LW x7
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd7, WB_MEM, 32'd40, 32'd0, 32'd0);
    ex (1'b1, OPCODE_OPIMM, 5'd1, 5'd5, 5'd6, WB_ALU, 32'd3, 32'd9, 32'd12, 1'b0, 32'd1);
    // LW x8 back-to-back, independent of x7
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd0, 5'd0, 5'd8, WB_MEM, 32'd0, 32'd0, 32'd0);
    ex (1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd7, WB_MEM, 32'd40, 32'd0, 32'd0, 1'b0, 32'd1);
    // STORE reading x7 and x8: stall only for the immediately preceding LW x8
    drv(1'b0, 1'b0, 1'b1, OPCODE_STORE, 5'd7, 5'd8, 5'd0, NO_WRITEBACK, 32'd1, 32'd2, 32'd4);
    ex (1'b1, OPCODE_LOAD, 5'd0, 5'd0, 5'd8, WB_MEM, 32'd0, 32'd0, 32'd0, 1'b1, 32'd1);
    // STORE held: bubble, no further stall (older LW x7 ignored)
    drv(1'b0, 1'b0, 1'b1, OPCODE_STORE, 5'd7, 5'd8, 5'd0, NO_WRITEBACK, 32'd1, 32'd2, 32'd4);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd2);
    // LW x5
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8);
    ex (1'b1, OPCODE_STORE, 5'd7, 5'd8, 5'd0, NO_WRITEBACK, 32'd1, 32'd2, 32'd4, 1'b0, 32'd2);
    // Load-use with flush the same cycle: no stall, flush bubble
    drv(1'b0, 1'b1, 1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0);
    ex (1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8, 1'b0, 32'd2);
    // Invalid slot capture: rd and wb_mux forced, other fields kept
    drv(1'b0, 1'b0, 1'b0, OPCODE_OP, 5'd4, 5'd5, 5'd9, WB_ALU, 32'd3, 32'd4, 32'd5);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd2);
    // LW x5
    drv(1'b0, 1'b0, 1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8);
    ex (1'b0, OPCODE_OP, 5'd4, 5'd5, 5'd0, NO_WRITEBACK, 32'd3, 32'd4, 32'd5, 1'b0, 32'd2);
    // Load-use cycle with reset asserted: stall suppressed
    drv(1'b1, 1'b0, 1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0);
    ex (1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd5, WB_MEM, 32'd100, 32'd0, 32'd8, 1'b0, 32'd2);
    // After reset: bubble, counter cleared; ADD still presented
    drv(1'b0, 1'b0, 1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0);
    ex (1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    // ADD captured after reset
    drv(1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 32'd0, 32'd0, 32'd0);
    ex (1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, WB_ALU, 32'd11, 32'd22, 32'd0, 1'b0, 32'd0);

    @(posedge clk);
    @(posedge clk);
    chk("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
